// File: rtl/switch_debouncer.sv
// Four-switch synchroniser/debouncer with a settle window that commits one clean 4-bit select code.
// Optional `SELECT_LOCK_EN adds the zakljucaj input that freezes commits while high.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch_1,
  input  logic       switch_2,
  input  logic       switch_3,
  input  logic       switch_4,
`ifdef SELECT_LOCK_EN
  input  logic       zakljucaj,
`endif
  output logic [3:0] odabrani_uzorak,
  output logic       novi_uzorak,
  output logic       stabilno
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {MIRUJE, SMIRIVANJE, POTVRDA} state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1_p0;
  logic [3:0]    sync2_p1;
  logic [3:0]    deb_p2;
  logic [DW-1:0] deb_cnt [4];
  logic [3:0]    kandidat;
  logic [SW-1:0] scnt;
  logic          lock;
  state_t        state;

  assign raw = {switch_1, switch_2, switch_3, switch_4};

`ifdef SELECT_LOCK_EN
  assign lock = zakljucaj;
`else
  assign lock = 1'b0;
`endif

  // Stage p0/p1: two-flop synchroniser per switch
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
    end else begin
      sync1_p0 <= raw;
      sync2_p1 <= sync1_p0;
    end
  end

  // Stage p2: per-bit debounce, level must persist DEBOUNCE_CYCLES clocks to flip
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_p2 <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_p1[i] != deb_p2[i]) begin
          if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_p2[i]  <= ~deb_p2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Settle FSM: the whole debounced vector must hold before it is committed
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= MIRUJE;
      kandidat        <= '0;
      scnt            <= '0;
      odabrani_uzorak <= '0;
      novi_uzorak     <= 1'b0;
    end else begin
      novi_uzorak <= 1'b0;
      case (state)
        MIRUJE: begin
          if (lock) begin
            scnt <= '0;
          end else if (deb_p2 != odabrani_uzorak) begin
            state    <= SMIRIVANJE;
            kandidat <= deb_p2;
            scnt     <= '0;
          end
        end
        SMIRIVANJE: begin
          if (lock) begin
            state <= MIRUJE;
            scnt  <= '0;
          end else if (deb_p2 == odabrani_uzorak) begin
            state <= MIRUJE;
          end else if (deb_p2 != kandidat) begin
            kandidat <= deb_p2;
            scnt     <= '0;
          end else if (scnt == SW'(SETTLE_CYCLES - 1)) begin
            state <= POTVRDA;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        POTVRDA: begin
          // Commit completes even if the lock rises in this cycle
          odabrani_uzorak <= kandidat;
          novi_uzorak     <= 1'b1;
          state           <= MIRUJE;
        end
        default: state <= MIRUJE;
      endcase
    end
  end

  assign stabilno = (state == MIRUJE);

endmodule
